// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: program sequencer owning the PC, program select and executed-instruction count
module inst_fetch_ctrl #(
   parameter int IW = 16,
   parameter int CW = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [1:0]    ProgSel,
   input  logic          Stall,
   input  logic          BranchEn,
   input  logic          BranchRel,
   input  logic [IW-1:0] Target,
   input  logic          Halt,
   output logic [IW-1:0] InstAddress,
   output logic [1:0]    ProgMux,
   output logic          Running,
   output logic          Done,
   output logic [CW-1:0] InstCount
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [IW-1:0] pc_n;
   logic [1:0] prog_n;
   logic [CW-1:0] cnt_n, cnt_inc;
   logic run, start_ok;
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         state <= IDLE;
         InstAddress <= '0;
         ProgMux <= 2'b00;
         InstCount <= '0;
      end else begin
         state <= state_n;
         InstAddress <= pc_n;
         ProgMux <= prog_n;
         InstCount <= cnt_n;
      end
   assign run = state == RUN;
   assign start_ok = !run && Start;
   assign Running = run;
   assign Done = state == DONE;
   always_comb
      state_n = run ? (Halt ? DONE : RUN) : (Start ? RUN : state);
   // Halt outranks Stall, which outranks a branch; the count saturates instead of wrapping
   always_comb begin
      cnt_inc = &InstCount ? InstCount : InstCount + 1'b1;
      prog_n = start_ok ? ProgSel : ProgMux;
      pc_n = start_ok ? '0
           : !run || Halt || Stall ? InstAddress
           : BranchEn ? (BranchRel ? InstAddress + Target : Target)
           : InstAddress + 1'b1;
      cnt_n = start_ok ? '0
            : !run || (Stall && !Halt) ? InstCount
            : cnt_inc;
   end
endmodule
